ascon_wave_sequencer: RTL and testbench
=======================================

Name: ascon_wave_sequencer

Overview:
- Controller that runs one ASCON AEAD encryption of an ECG wave buffer on the shared ascon core.
- Phase order: initialisation, one associated-data block, NWORDS plaintext words, finalisation/tag.
- Drives the core's phase strobes and data word, and counts the word index.
- Gathers the returned cipher words into a wave register that the UART FSM transmits.

Parameters:
NWORDS, 23, number of 64-bit plaintext words per wave (23*64 = 1472 bits)
TIMEOUT, 1024, max cycles spent in any WAIT_* state before abort

Ports:
clock_i  in  1  main clock
resetb_i  in  1  asynchronous reset, active low
start_i  in  1  one-cycle start request from UART FSM
ad_i  in  64  associated data block
wave_i  in  NWORDS*64  plaintext; word k = bits [NWORDS*64-1-64k -: 64] (word 0 at MSBs)
end_initialisation_i  in  1  core finished initialisation
end_associate_i  in  1  core finished AD absorption
end_cipher_i  in  1  core finished one plaintext block
cipher_valid_i  in  1  cipher_i valid this cycle
cipher_i  in  64  cipher word from core
end_tag_i  in  1  tag ready; encryption complete
init_o  out  1  initialisation pulse to core
associate_data_o  out  1  AD-valid pulse
data_valid_o  out  1  plaintext-valid pulse
finalisation_o  out  1  final-block flag, asserted with the last data_valid_o
data_o  out  64  word to core: ad_i in AD state, else wave word word_idx_o
word_idx_o  out  5  current plaintext word index
busy_o  out  1  high whenever state != IDLE
done_o  out  1  one-cycle pulse on successful completion
error_o  out  1  sticky timeout flag
cipher_wave_o  out  NWORDS*64  captured cipher words, same packing as wave_i

Behaviour:
- Reset (async, resetb_i=0):
  - state=IDLE; every output 0; word index 0; cipher_wave_o and timeout counter cleared.
  - Reset mid-operation aborts the run immediately, with no done_o.
- Strobes are registered. All *_o pulses are exactly one cycle wide.
- States and transitions:
  - IDLE: start_i=1 -> INIT. In the same cycle: clear error_o, word index, cipher_wave_o.
  - INIT: init_o=1 for one cycle -> WAIT_INIT.
  - WAIT_INIT: end_initialisation_i -> AD.
  - AD: data_o=ad_i, associate_data_o=1 for one cycle -> WAIT_AD.
  - WAIT_AD: end_associate_i -> DATA.
  - DATA: data_o=wave word[idx], data_valid_o=1 for one cycle.
    - If idx==NWORDS-1, finalisation_o=1 in the same cycle -> WAIT_TAG.
    - Otherwise -> WAIT_DATA.
  - WAIT_DATA: end_cipher_i -> idx+1, -> DATA.
  - WAIT_TAG: end_tag_i -> DONE.
  - DONE: done_o=1 for one cycle -> IDLE.
- data_o is held stable from the DATA/AD cycle until the matching end_* input arrives.
- Cipher capture:
  - Any cycle with cipher_valid_i=1 while in WAIT_DATA or WAIT_TAG writes cipher_i into slot word_idx_o.
  - cipher_valid_i in any other state is ignored.
  - A second cipher_valid_i for the same index overwrites that slot.
- cipher_wave_o holds its value after DONE until the next accepted start.
- The end_* inputs are honoured only in their matching WAIT state; stray assertions are ignored.
- end_cipher_i and cipher_valid_i in the same cycle: capture into the current idx first, then increment.
- start_i while busy_o=1 is ignored; it is not queued.
- Timeout:
  - The counter resets on entry to each WAIT_* state and increments every cycle while waiting.
  - When it reaches TIMEOUT-1 with no end event: error_o=1, -> IDLE, no done_o.
  - error_o stays set until the next accepted start_i or reset.
- Index range: idx runs 0..NWORDS-1 and never wraps. The 5-bit index requires NWORDS<=32.
- Latency from start_i to done_o: 5 + 2*NWORDS + sum of the core wait cycles.

Test Plan:
- Nominal run: a core model answers each strobe after 12 cycles; wave word k=64'h0101_0101_0101_0101*k; cipher_i=word^64'hFFFF_FFFF_FFFF_FFFF. Required: 23 data_valid_o pulses, finalisation_o only with word 22, one done_o, cipher_wave_o = ~wave_i, error_o=0.
- start_i pulsed during WAIT_DATA at idx=5: ignored; word_idx_o sequence and pulse counts unchanged versus the nominal run.
- Core never raises end_associate_i, TIMEOUT=16: error_o=1 exactly 16 cycles after entering WAIT_AD, state IDLE, busy_o=0, no done_o. A following start clears error_o.
- resetb_i=0 for 1 cycle at idx=10: every output 0 immediately (async). A new start then runs the complete nominal sequence from idx 0.
- Stray end_cipher_i in WAIT_INIT and cipher_valid_i in IDLE: no state change, cipher_wave_o stays 0.
- end_cipher_i coincident with cipher_valid_i at idx=3: slot 3 = cipher_i, word_idx_o becomes 4 on the next DATA cycle.

Source files
------------

// File: rtl/ascon_wave_sequencer_if.sv
// Bundle of every signal between the wave sequencer, the UART FSM and the
// shared ascon core. The sequencer uses the master view; whoever drives the
// requests and the core answers uses the slave view.
//
// Handshake: each *_o strobe (init_o, associate_data_o, data_valid_o,
// finalisation_o, done_o) is a registered pulse exactly one cycle wide.
// The core answers with a one-cycle end_* pulse, which counts only while the
// sequencer waits in the matching state; data_o stays stable from the strobe
// until that answer. cipher_valid_i qualifies cipher_i for one cycle and is
// accepted only while a plaintext word or the tag is outstanding.
interface ascon_wave_sequencer_if #(
  parameter int NWORDS = 23
);
  logic                  start_i;
  logic [63:0]           ad_i;
  logic [NWORDS*64-1:0]  wave_i;
  logic                  end_initialisation_i;
  logic                  end_associate_i;
  logic                  end_cipher_i;
  logic                  cipher_valid_i;
  logic [63:0]           cipher_i;
  logic                  end_tag_i;
  logic                  init_o;
  logic                  associate_data_o;
  logic                  data_valid_o;
  logic                  finalisation_o;
  logic [63:0]           data_o;
  logic [4:0]            word_idx_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  error_o;
  logic [NWORDS*64-1:0]  cipher_wave_o;

  modport master (
    input  start_i, ad_i, wave_i, end_initialisation_i, end_associate_i,
           end_cipher_i, cipher_valid_i, cipher_i, end_tag_i,
    output init_o, associate_data_o, data_valid_o, finalisation_o, data_o,
           word_idx_o, busy_o, done_o, error_o, cipher_wave_o
  );

  modport slave (
    output start_i, ad_i, wave_i, end_initialisation_i, end_associate_i,
           end_cipher_i, cipher_valid_i, cipher_i, end_tag_i,
    input  init_o, associate_data_o, data_valid_o, finalisation_o, data_o,
           word_idx_o, busy_o, done_o, error_o, cipher_wave_o
  );
endinterface

// File: rtl/ascon_wave_sequencer.sv
// Runs one ASCON AEAD encryption of an ECG wave buffer on the shared core:
// initialisation, one associated-data block, NWORDS plaintext words, tag.
// Returned cipher words are gathered into cipher_wave_o for the UART FSM.
// Every WAIT_* state is guarded by a timeout that aborts with a sticky error.
// The 5-bit word index limits NWORDS to at most 32.
module ascon_wave_sequencer #(
  parameter int NWORDS  = 23,
  parameter int TIMEOUT = 1024
) (
  input  logic                          clock_i,
  input  logic                          resetb_i,
  ascon_wave_sequencer_if.master        bus,
  output logic [3:0]                    state_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_WAIT_INIT, S_AD, S_WAIT_AD,
    S_DATA, S_WAIT_DATA, S_WAIT_TAG, S_DONE
  } state_t;

  localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [4:0]    LAST_IDX = 5'(NWORDS - 1);

  state_t        state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [CW-1:0] tmo_q;
  logic          wait_st;
  logic          timed_out;
  logic          accept_start;
  logic [63:0]   wave_words [NWORDS];
  logic [63:0]   cipher_q   [NWORDS];

  // Word k of the plaintext sits at the MSB end for k = 0; the cipher wave
  // uses the same packing.
  for (genvar k = 0; k < NWORDS; k++) begin : g_pack
    assign wave_words[k] = bus.wave_i[NWORDS*64-1-64*k -: 64];
    assign bus.cipher_wave_o[NWORDS*64-1-64*k -: 64] = cipher_q[k];
  end

  assign state_o    = state_q;
  assign bus.word_idx_o = idx_q;
  assign accept_start = (state_q == S_IDLE) && bus.start_i;
  assign wait_st    = (state_q == S_WAIT_INIT) || (state_q == S_WAIT_AD) ||
                      (state_q == S_WAIT_DATA) || (state_q == S_WAIT_TAG);

  // Next-state and next-index logic, including the timeout abort.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    timed_out = 1'b0;
    unique case (state_q)
      S_IDLE:      if (bus.start_i) begin
                     state_d = S_INIT;
                     idx_d   = '0;
                   end
      S_INIT:      state_d = S_WAIT_INIT;
      S_WAIT_INIT: if (bus.end_initialisation_i) state_d = S_AD;
      S_AD:        state_d = S_WAIT_AD;
      S_WAIT_AD:   if (bus.end_associate_i) state_d = S_DATA;
      S_DATA:      state_d = (idx_q == LAST_IDX) ? S_WAIT_TAG : S_WAIT_DATA;
      S_WAIT_DATA: if (bus.end_cipher_i) begin
                     idx_d   = idx_q + 5'd1;
                     state_d = S_DATA;
                   end
      S_WAIT_TAG:  if (bus.end_tag_i) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    // No end event on the last allowed waiting cycle: give up.
    if (wait_st && (state_d == state_q) && (tmo_q == TMO_LAST)) begin
      timed_out = 1'b1;
      state_d   = S_IDLE;
    end
  end

  // State, index and wait-cycle counter; the counter restarts on every state change.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_d != state_q) tmo_q <= '0;
      else if (wait_st)       tmo_q <= tmo_q + 1'b1;
    end
  end

  // Registered strobes, data word and sticky error, decoded from the next state.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      bus.init_o           <= 1'b0;
      bus.associate_data_o <= 1'b0;
      bus.data_valid_o     <= 1'b0;
      bus.finalisation_o   <= 1'b0;
      bus.done_o           <= 1'b0;
      bus.busy_o           <= 1'b0;
      bus.error_o          <= 1'b0;
      bus.data_o           <= '0;
    end else begin
      bus.init_o           <= (state_d == S_INIT);
      bus.associate_data_o <= (state_d == S_AD);
      bus.data_valid_o     <= (state_d == S_DATA);
      bus.finalisation_o   <= (state_d == S_DATA) && (idx_d == LAST_IDX);
      bus.done_o           <= (state_d == S_DONE);
      bus.busy_o           <= (state_d != S_IDLE);
      if (state_d == S_AD)        bus.data_o <= bus.ad_i;
      else if (state_d == S_DATA) bus.data_o <= wave_words[idx_d];
      if (accept_start)   bus.error_o <= 1'b0;
      else if (timed_out) bus.error_o <= 1'b1;
    end
  end

  // Cipher capture into the slot of the word currently outstanding.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      for (int k = 0; k < NWORDS; k++) cipher_q[k] <= '0;
    end else if (accept_start) begin
      for (int k = 0; k < NWORDS; k++) cipher_q[k] <= '0;
    end else if (bus.cipher_valid_i &&
                 ((state_q == S_WAIT_DATA) || (state_q == S_WAIT_TAG))) begin
      cipher_q[idx_q] <= bus.cipher_i;
    end
  end

endmodule

// File: tb/tb_ascon_wave_sequencer.sv
// Bench for ascon_wave_sequencer: a reactive core model answers the strobes,
// a monitor records strobe activity, and per-scenario tasks compare what was
// recorded with a word-level model of one encryption run.
module tb_ascon_wave_sequencer;
  localparam int NW  = 23;
  localparam int TMO = 16;
  localparam int WB  = NW * 64;

  // ---------------- clock / reset ----------------
  logic       clock_i  = 1'b0;
  logic       resetb_i = 1'b0;
  logic [3:0] state_o;
  always #5 clock_i = ~clock_i;

  ascon_wave_sequencer_if #(.NWORDS(NW)) bus ();
  ascon_wave_sequencer #(.NWORDS(NW), .TIMEOUT(TMO)) dut (
    .clock_i (clock_i),
    .resetb_i(resetb_i),
    .bus     (bus),
    .state_o (state_o)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- core model ----------------
  logic        core_end_init, core_end_ad, core_end_cipher, core_end_tag, core_cv;
  logic [63:0] core_cipher;
  logic        inj_end_cipher = 1'b0, inj_cv = 1'b0;
  logic [63:0] inj_cipher = '0;
  int          core_delay = 12;
  bit          drop_ad = 1'b0, coincide_all = 1'b0, dup_mode = 1'b0;
  logic [63:0] mask = '1;

  assign bus.end_initialisation_i = core_end_init;
  assign bus.end_associate_i      = core_end_ad;
  assign bus.end_cipher_i         = core_end_cipher | inj_end_cipher;
  assign bus.end_tag_i            = core_end_tag;
  assign bus.cipher_valid_i       = core_cv | inj_cv;
  assign bus.cipher_i             = inj_cv ? inj_cipher : core_cipher;

  initial begin : core_model
    int pend, cnt, dcount;
    bit co;
    logic [63:0] word;
    pend = 0; cnt = 0; dcount = 0; word = '0;
    core_end_init = 0; core_end_ad = 0; core_end_cipher = 0; core_end_tag = 0;
    core_cv = 0; core_cipher = '0;
    forever begin
      @(negedge clock_i);
      core_end_init = 0; core_end_ad = 0; core_end_cipher = 0; core_end_tag = 0;
      core_cv = 0;
      if (!resetb_i) begin
        pend = 0; dcount = 0;
      end else if (pend == 0) begin
        if (bus.init_o) begin
          pend = 1; cnt = core_delay; dcount = 0;
        end else if (bus.associate_data_o) begin
          pend = drop_ad ? 0 : 2; cnt = core_delay;
        end else if (bus.data_valid_o) begin
          pend = bus.finalisation_o ? 4 : 3; cnt = core_delay; word = bus.data_o;
        end
      end else begin
        cnt--;
        co = coincide_all || (dcount == 3) || (core_delay < 2);
        if (pend >= 3 && dup_mode && cnt == 2) begin
          core_cv = 1; core_cipher = ~word ^ 64'h5A5A_0F0F_A5A5_F0F0;
        end
        if (pend >= 3 && !co && cnt == 1) begin
          core_cv = 1; core_cipher = word ^ mask;
        end
        if (cnt == 0) begin
          case (pend)
            1: core_end_init = 1;
            2: core_end_ad = 1;
            3: core_end_cipher = 1;
            default: core_end_tag = 1;
          endcase
          if (pend >= 3 && co) begin
            core_cv = 1; core_cipher = word ^ mask;
          end
          if (pend >= 3) dcount++;
          pend = 0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int          run_id = 0;
  bit          mon_en = 1'b0;
  int          mon_init, mon_done, mon_wide, mon_hold;
  logic [4:0]  dv_idx_q [$];
  logic [63:0] dv_data_q [$];
  logic [4:0]  fin_idx_q [$];
  logic [63:0] ad_data_q [$];

  initial begin : monitor
    int last_id;
    logic [4:0]  prev_str, cur_str;
    logic [63:0] prev_data;
    last_id = 0; prev_str = '0; prev_data = '0;
    mon_init = 0; mon_done = 0; mon_wide = 0; mon_hold = 0;
    forever begin
      @(negedge clock_i);
      if (run_id != last_id) begin
        last_id = run_id;
        mon_init = 0; mon_done = 0; mon_wide = 0; mon_hold = 0;
        dv_idx_q.delete(); dv_data_q.delete(); fin_idx_q.delete(); ad_data_q.delete();
      end
      cur_str = {bus.init_o, bus.associate_data_o, bus.data_valid_o,
                 bus.finalisation_o, bus.done_o};
      if (mon_en) begin
        if (bus.data_valid_o) begin
          dv_idx_q.push_back(bus.word_idx_o);
          dv_data_q.push_back(bus.data_o);
        end
        if (bus.finalisation_o)   fin_idx_q.push_back(bus.word_idx_o);
        if (bus.associate_data_o) ad_data_q.push_back(bus.data_o);
        if (bus.init_o) mon_init++;
        if (bus.done_o) mon_done++;
        if ((prev_str & cur_str) != '0) mon_wide++;
        if (bus.data_o !== prev_data && !bus.associate_data_o && !bus.data_valid_o)
          mon_hold++;
      end
      prev_str  = cur_str;
      prev_data = bus.data_o;
    end
  end

  // ---------------- reference model ----------------
  logic [63:0] pt [NW];
  logic [63:0] exp_ct [NW];
  logic [63:0] ad_val;

  function automatic logic [WB-1:0] pack_words(input logic [63:0] w [NW]);
    logic [WB-1:0] r;
    r = '0;
    for (int k = 0; k < NW; k++) r = (r << 64) | WB'(w[k]);
    return r;
  endfunction

  function automatic logic [63:0] get_slot(input logic [WB-1:0] v, input int k);
    logic [WB-1:0] t;
    t = v >> (64 * (NW - 1 - k));
    return t[63:0];
  endfunction

  // Plaintext, AD and mask for one run; expected cipher is plaintext ^ mask.
  task automatic setup_run(input bit nominal);
    for (int k = 0; k < NW; k++) begin
      pt[k] = nominal ? 64'h0101_0101_0101_0101 * 64'(k) : {$urandom, $urandom};
    end
    mask   = nominal ? '1 : {$urandom, $urandom};
    ad_val = {$urandom, $urandom};
    for (int k = 0; k < NW; k++) exp_ct[k] = pt[k] ^ mask;
    bus.wave_i = pack_words(pt);
    bus.ad_i   = ad_val;
  endtask

  // ---------------- driver tasks ----------------
  task automatic begin_run();
    run_id++;
    @(negedge clock_i);
    bus.start_i = 1'b1;
    @(negedge clock_i);
    bus.start_i = 1'b0;
  endtask

  task automatic wait_end(input string name);
    bit seen;
    seen = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      if (bus.done_o) seen = 1;
      else if (bus.error_o) c = 3000;
      else @(negedge clock_i);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s run_end: done_o not seen (error_o=%0b) required done within budget",
               name, bus.error_o);
    end
    repeat (3) @(negedge clock_i);
  endtask

  task automatic check_run(input string name);
    int bad;
    checks++;
    if (dv_idx_q.size() !== NW) begin
      errors++;
      $display("FAIL %s dv_count: got %0d required %0d", name, dv_idx_q.size(), NW);
    end
    bad = 0;
    for (int k = 0; k < NW && k < dv_idx_q.size(); k++)
      if (dv_idx_q[k] !== 5'(k) || dv_data_q[k] !== pt[k]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s word_seq: %0d words with wrong index/data, required 0", name, bad);
    end
    checks++;
    if (fin_idx_q.size() !== 1 || fin_idx_q[0] !== 5'(NW - 1)) begin
      errors++;
      $display("FAIL %s finalisation: got %0d pulses (first idx %0d) required 1 at idx %0d",
               name, fin_idx_q.size(), (fin_idx_q.size() > 0) ? fin_idx_q[0] : 5'd0, NW - 1);
    end
    checks++;
    if (ad_data_q.size() !== 1 || ad_data_q[0] !== ad_val) begin
      errors++;
      $display("FAIL %s ad_block: got %0d pulses data %h required 1 with %h", name,
               ad_data_q.size(), (ad_data_q.size() > 0) ? ad_data_q[0] : 64'h0, ad_val);
    end
    checks++;
    if (mon_init !== 1 || mon_done !== 1) begin
      errors++;
      $display("FAIL %s init_done: got init=%0d done=%0d required 1/1", name, mon_init, mon_done);
    end
    checks++;
    if (bus.error_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s end_flags: got error=%b busy=%b required 0/0", name, bus.error_o, bus.busy_o);
    end
    checks++;
    if (bus.cipher_wave_o !== pack_words(exp_ct)) begin
      errors++;
      $display("FAIL %s cipher_wave: slot0 got %h required %h", name,
               get_slot(bus.cipher_wave_o, 0), exp_ct[0]);
    end
    checks++;
    if (mon_wide !== 0 || mon_hold !== 0) begin
      errors++;
      $display("FAIL %s pulse_shape: got wide=%0d hold_changes=%0d required 0/0",
               name, mon_wide, mon_hold);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [WB-1:0] zw;
    zw = '0;
    checks++;
    if ({bus.init_o, bus.associate_data_o, bus.data_valid_o, bus.finalisation_o,
         bus.busy_o, bus.done_o, bus.error_o} !== 7'b0) begin
      errors++;
      $display("FAIL %s flags: got %b required 0000000", name,
               {bus.init_o, bus.associate_data_o, bus.data_valid_o, bus.finalisation_o,
                bus.busy_o, bus.done_o, bus.error_o});
    end
    checks++;
    if (bus.data_o !== 64'h0 || bus.word_idx_o !== 5'd0 || bus.cipher_wave_o !== zw) begin
      errors++;
      $display("FAIL %s data_idx_wave: got data=%h idx=%0d slot0=%h required 0", name,
               bus.data_o, bus.word_idx_o, get_slot(bus.cipher_wave_o, 0));
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.start_i = 0; bus.ad_i = '0; bus.wave_i = '0;
    resetb_i = 0;
    repeat (3) @(negedge clock_i);
    check_all_zero("reset_hold");
    resetb_i = 1;
    repeat (2) @(negedge clock_i);
    check_all_zero("reset_release");
    mon_en = 1;
  endtask

  task automatic test_stray_idle();
    logic [WB-1:0] zw;
    zw = '0;
    inj_cv = 1; inj_cipher = {$urandom, $urandom}; inj_end_cipher = 1;
    @(negedge clock_i);
    inj_cv = 0; inj_end_cipher = 0;
    repeat (2) @(negedge clock_i);
    checks++;
    if (bus.cipher_wave_o !== zw || bus.busy_o !== 1'b0 || bus.word_idx_o !== 5'd0) begin
      errors++;
      $display("FAIL stray_idle: got slot0=%h busy=%b idx=%0d required 0/0/0",
               get_slot(bus.cipher_wave_o, 0), bus.busy_o, bus.word_idx_o);
    end
  endtask

  task automatic test_nominal();
    core_delay = 12; coincide_all = 0; dup_mode = 0;
    setup_run(1);
    begin_run();
    wait_end("nominal");
    check_run("nominal");
    checks++;
    if (bus.cipher_wave_o !== ~bus.wave_i) begin
      errors++;
      $display("FAIL nominal not_wave: slot22 got %h required %h",
               get_slot(bus.cipher_wave_o, NW - 1), ~pt[NW - 1]);
    end
    checks++;
    if (get_slot(bus.cipher_wave_o, 3) !== ~pt[3]) begin
      errors++;
      $display("FAIL nominal slot3_coincident: got %h required %h",
               get_slot(bus.cipher_wave_o, 3), ~pt[3]);
    end
  endtask

  task automatic test_busy_start();
    bit hit;
    hit = 0;
    core_delay = 12;
    setup_run(0);
    begin_run();
    for (int c = 0; c < 2000 && !hit; c++) begin
      if (bus.word_idx_o == 5'd5 && bus.busy_o && !bus.data_valid_o) hit = 1;
      else @(negedge clock_i);
    end
    bus.start_i = 1;
    @(negedge clock_i);
    bus.start_i = 0;
    checks++;
    if (!hit || bus.word_idx_o !== 5'd5 || bus.init_o !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_reach: hit=%0b idx=%0d init=%b required 1/5/0",
               hit, bus.word_idx_o, bus.init_o);
    end
    wait_end("busy_start");
    check_run("busy_start");
  endtask

  task automatic test_stray_wait_init();
    core_delay = 12;
    setup_run(0);
    begin_run();
    @(negedge clock_i);
    inj_end_cipher = 1; inj_cv = 1; inj_cipher = {$urandom, $urandom};
    @(negedge clock_i);
    inj_end_cipher = 0; inj_cv = 0;
    @(negedge clock_i);
    checks++;
    if (bus.busy_o !== 1'b1 || bus.word_idx_o !== 5'd0 || dv_idx_q.size() !== 0 ||
        ad_data_q.size() !== 0) begin
      errors++;
      $display("FAIL stray_wait_init: busy=%b idx=%0d dv=%0d ad=%0d required 1/0/0/0",
               bus.busy_o, bus.word_idx_o, dv_idx_q.size(), ad_data_q.size());
    end
    wait_end("stray_wait_init");
    check_run("stray_wait_init");
    inj_cv = 1; inj_cipher = ~exp_ct[0];
    @(negedge clock_i);
    inj_cv = 0;
    repeat (2) @(negedge clock_i);
    checks++;
    if (bus.cipher_wave_o !== pack_words(exp_ct)) begin
      errors++;
      $display("FAIL idle_hold_wave: slot0 got %h required %h",
               get_slot(bus.cipher_wave_o, 0), exp_ct[0]);
    end
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 4; r++) begin
      core_delay   = $urandom_range(1, 12);
      coincide_all = (r == 1);
      dup_mode     = (r >= 2);
      if (dup_mode && core_delay < 3) core_delay = 3;
      setup_run(0);
      begin_run();
      wait_end($sformatf("random%0d", r));
      check_run($sformatf("random%0d", r));
    end
    coincide_all = 0; dup_mode = 0;
  endtask

  task automatic test_timeout();
    int first;
    bit seen_ad;
    first = 0; seen_ad = 0;
    core_delay = 5; drop_ad = 1;
    setup_run(0);
    begin_run();
    for (int c = 0; c < 100 && !seen_ad; c++) begin
      if (bus.associate_data_o) seen_ad = 1;
      else @(negedge clock_i);
    end
    for (int k = 1; k <= 24 && first == 0; k++) begin
      @(negedge clock_i);
      if (bus.error_o) first = k;
    end
    checks++;
    if (!seen_ad || first !== 17) begin
      errors++;
      $display("FAIL timeout_latency: error_o at negedge %0d after AD (ad_seen=%0b) required 17",
               first, seen_ad);
    end
    repeat (3) @(negedge clock_i);
    checks++;
    if (bus.error_o !== 1'b1 || bus.busy_o !== 1'b0 || mon_done !== 0 || bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_state: error=%b busy=%b dones=%0d required 1/0/0",
               bus.error_o, bus.busy_o, mon_done);
    end
    drop_ad = 0; core_delay = 12;
    setup_run(0);
    begin_run();
    checks++;
    if (bus.error_o !== 1'b0 || bus.init_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_clear: error=%b init=%b required 0/1", bus.error_o, bus.init_o);
    end
    wait_end("after_timeout");
    check_run("after_timeout");
  endtask

  task automatic test_reset_mid();
    bit hit;
    int dones;
    hit = 0; dones = 0;
    core_delay = 12;
    setup_run(0);
    begin_run();
    for (int c = 0; c < 2000 && !hit; c++) begin
      if (bus.word_idx_o == 5'd10) hit = 1;
      else @(negedge clock_i);
    end
    mon_en = 0;
    #2 resetb_i = 0;
    #1;
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid_reach: idx 10 not reached, required reached");
    end
    check_all_zero("reset_mid_async");
    @(negedge clock_i);
    #2 resetb_i = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock_i);
      if (bus.done_o || bus.busy_o) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL reset_mid_abort: %0d cycles with done/busy after reset, required 0", dones);
    end
    mon_en = 1;
    setup_run(0);
    begin_run();
    wait_end("after_reset");
    check_run("after_reset");
  endtask

  // ---------------- main sequence and report ----------------
  initial begin : main
    test_reset();
    test_stray_idle();
    test_nominal();
    test_busy_start();
    test_stray_wait_init();
    test_random_runs();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
